// File: rtl/fetch_sched_pkg.sv
// Shared types and widths for the fetch scheduler: state encoding,
// register-index width, perf counter width and a saturating increment.
package fetch_sched_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        REDIRECT = 2'd3
    } sched_state_t;

    localparam int REG_IDX_W = 5;
    localparam int PERF_W    = 16;

    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
        return (value == PERF_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/load_use_detect_da.sv
// Combinational load-use hazard detector: a load in EX whose destination
// (non-zero) matches either source register of the instruction in ID.
module load_use_detect_da
    import fetch_sched_pkg::*;
(
    input  logic                 idex_mem_read,
    input  logic [REG_IDX_W-1:0] idex_rt,
    input  logic [REG_IDX_W-1:0] ifid_rs,
    input  logic [REG_IDX_W-1:0] ifid_rt,
    output logic                 load_use
);

    logic [REG_IDX_W-1:0] src [2];
    logic [1:0]           src_match;

    assign src[0] = ifid_rs;
    assign src[1] = ifid_rt;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_match[gi] = (src[gi] == idex_rt);
    end

    // Register 0 is hardwired to zero, so a load into it never creates a hazard.
    assign load_use = idex_mem_read & (idex_rt != '0) & (|src_match);

endmodule

// File: rtl/fetch_sched_da.sv
// Fetch/ID pipeline scheduler: boot hold-off, imem wait states, branch
// redirect flushes and load-use stalls. Perf counters under FETCH_SCHED_PERF_EN.
module fetch_sched_da
    import fetch_sched_pkg::*;
#(
    parameter int BOOT_CYCLES      = 2,
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 idex_mem_read,
    input  logic [REG_IDX_W-1:0] idex_rt,
    input  logic [REG_IDX_W-1:0] ifid_rs,
    input  logic [REG_IDX_W-1:0] ifid_rt,
    input  logic                 pcsrc,
    input  logic                 mem_wait,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 if_flush,
    output logic                 id_bubble,
    output logic [1:0]           sched_state,
    output logic [PERF_W-1:0]    stall_cycles,
    output logic [PERF_W-1:0]    flush_cycles
);

    localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [2:0] REDIR_LOAD = (REDIRECT_BUBBLES > 1) ? 3'(REDIRECT_BUBBLES - 2) : 3'd0;

    sched_state_t state_reg, state_next;
    logic [3:0]   boot_cnt_reg, boot_cnt_next;
    logic [2:0]   redir_cnt_reg, redir_cnt_next;
    logic         load_use;

    load_use_detect_da u_load_use (
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .load_use      (load_use)
    );

    always_comb begin
        state_next     = state_reg;
        boot_cnt_next  = boot_cnt_reg;
        redir_cnt_next = redir_cnt_reg;
        pc_write       = 1'b0;
        ifid_write     = 1'b0;
        if_flush       = 1'b1;
        id_bubble      = 1'b1;

        if (reset) begin
            state_next     = BOOT;
            boot_cnt_next  = '0;
            redir_cnt_next = '0;
        end else begin
            case (state_reg)
                BOOT: begin
                    if (boot_cnt_reg == BOOT_LAST) begin
                        state_next    = RUN;
                        boot_cnt_next = '0;
                    end else begin
                        boot_cnt_next = boot_cnt_reg + 4'd1;
                    end
                end

                RUN: begin
                    if (mem_wait) begin
                        if_flush   = 1'b0;
                        state_next = MEM_WAIT;
                    end else if (pcsrc) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        id_bubble  = 1'b0;
                        if (REDIRECT_BUBBLES > 1) begin
                            redir_cnt_next = REDIR_LOAD;
                            state_next     = REDIRECT;
                        end
                    end else if (load_use) begin
                        if_flush = 1'b0;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        if_flush   = 1'b0;
                        id_bubble  = 1'b0;
                    end
                end

                // ID is frozen while waiting, so a pending branch is re-evaluated in RUN.
                MEM_WAIT: begin
                    if_flush = 1'b0;
                    if (!mem_wait) begin
                        state_next = RUN;
                    end
                end

                REDIRECT: begin
                    if (mem_wait) begin
                        if_flush = 1'b0;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        id_bubble  = 1'b0;
                        if (redir_cnt_reg == 3'd0) begin
                            state_next = RUN;
                        end else begin
                            redir_cnt_next = redir_cnt_reg - 3'd1;
                        end
                    end
                end

                default: begin
                    state_next = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= BOOT;
            boot_cnt_reg  <= '0;
            redir_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            boot_cnt_reg  <= boot_cnt_next;
            redir_cnt_reg <= redir_cnt_next;
        end
    end

    assign sched_state = reset ? BOOT : state_reg;

`ifdef FETCH_SCHED_PERF_EN
    logic [PERF_W-1:0] stall_cnt_reg;
    logic [PERF_W-1:0] flush_cnt_reg;
    logic              perf_active;

    assign perf_active = !reset && (state_reg != BOOT);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (perf_active) begin
            if (!pc_write) begin
                stall_cnt_reg <= sat_inc(stall_cnt_reg);
            end
            if (if_flush) begin
                flush_cnt_reg <= sat_inc(flush_cnt_reg);
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_cycles = flush_cnt_reg;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule
